slice_alu_mul: RTL

- Parametrised successor of the 4-bit Am2901 bit-slice: same 9-bit source/function/destination microinstruction set.
- Generalised to WIDTH bits and DEPTH registers.
- Adds a built-in unsigned shift-and-add multiply sequencer that runs autonomously for WIDTH+1 cycles.
- Sits behind the microprogram controller as a self-contained datapath+control slice; no external cascade wiring.

---
 rtl/slice_pkg.sv | 27 ++
 rtl/slice_alu_mul_if.sv | 28 ++
 rtl/slice_alu.sv | 43 ++++
 rtl/slice_alu_mul.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/slice_pkg.sv
// slice_pkg: shared decode types for the slice_alu_mul bit-slice datapath.
//   src_e   - operand source select (i[2:0])
//   fn_e    - ALU function select  (i[5:3])
//   dst_e   - destination / shift control (i[8:6])
//   state_e - multiply sequencer states
package slice_pkg;

  typedef enum logic [2:0] {
    SRC_AQ, SRC_AB, SRC_ZQ, SRC_ZB, SRC_ZA, SRC_DA, SRC_DQ, SRC_DZ
  } src_e;

  // FN_SUBR = S + ~R + cin, FN_SUBS = R + ~S + cin, FN_NOTRS = ~R & S
  typedef enum logic [2:0] {
    FN_ADD, FN_SUBR, FN_SUBS, FN_OR, FN_AND, FN_NOTRS, FN_EXOR, FN_EXNOR
  } fn_e;

  typedef enum logic [2:0] {
    DST_QREG, DST_NOP, DST_RAMA, DST_RAMF, DST_RAMQD, DST_RAMD, DST_RAMQU, DST_RAMU
  } dst_e;

  typedef enum logic [1:0] {IDLE, CLR, MUL, DONE} state_e;

  localparam int I_SRC_LO = 0;
  localparam int I_FN_LO  = 3;
  localparam int I_DST_LO = 6;

endpackage

// File: rtl/slice_alu_mul_if.sv
// slice_alu_mul_if: microinstruction/control bus of the slice.
//   master (controller): drives i, a, b, d, cin, ser_in, oe, start;
//                        observes cout, ovr, z, fmsb, busy, done.
//   slave  (slice):      the reverse.
interface slice_alu_mul_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) ();
  logic [8:0]       i;
  logic [AW-1:0]    a;
  logic [AW-1:0]    b;
  logic [WIDTH-1:0] d;
  logic             cin;
  logic             ser_in;
  logic             oe;
  logic             start;
  logic             cout;
  logic             ovr;
  logic             z;
  logic             fmsb;
  logic             busy;
  logic             done;

  modport master (output i, a, b, d, cin, ser_in, oe, start,
                  input  cout, ovr, z, fmsb, busy, done);
  modport slave  (input  i, a, b, d, cin, ser_in, oe, start,
                  output cout, ovr, z, fmsb, busy, done);
endinterface

// File: rtl/slice_alu.sv
// slice_alu: combinational WIDTH-bit ALU.
//   r, s, cin, fn -> f, cout (carry out of MSB), ovr (signed overflow).
//   Logic functions force cout and ovr low.
module slice_alu import slice_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] s,
  input  logic             cin,
  input  fn_e              fn,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             ovr
);
  logic [WIDTH-1:0] op_r, op_s;
  logic [WIDTH:0]   sum;
  logic             c_msb;

  always_comb begin
    op_r = r;
    op_s = s;
    if (fn == FN_SUBR) op_r = ~r;
    if (fn == FN_SUBS) op_s = ~s;
    sum   = {1'b0, op_r} + {1'b0, op_s} + {{WIDTH{1'b0}}, cin};
    // carry into the MSB recovered from the MSB sum bit and its operands
    c_msb = sum[WIDTH-1] ^ op_r[WIDTH-1] ^ op_s[WIDTH-1];
    f     = sum[WIDTH-1:0];
    cout  = sum[WIDTH];
    ovr   = c_msb ^ sum[WIDTH];
    case (fn)
      FN_OR:    f = r | s;
      FN_AND:   f = r & s;
      FN_NOTRS: f = ~r & s;
      FN_EXOR:  f = r ^ s;
      FN_EXNOR: f = ~(r ^ s);
      default:  ;
    endcase
    if (fn inside {FN_OR, FN_AND, FN_NOTRS, FN_EXOR, FN_EXNOR}) begin
      cout = 1'b0;
      ovr  = 1'b0;
    end
  end
endmodule

// File: rtl/slice_alu_mul.sv
// slice_alu_mul: Am2901-style bit slice with built-in shift-and-add multiplier.
//   cp, rst_lo : clock / async active-low reset
//   bus        : microinstruction + flags/handshake (slice_alu_mul_if.slave)
//   y          : tri-state result bus (F, or A-port for RAMA); kept as a plain
//                port so the tri-state driver lives at the module boundary.
// Multiply: Q holds the multiplier; start latches a (multiplicand) and
// b (high word). Result high word lands in RAM[b_l], low word in Q.
module slice_alu_mul import slice_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             cp,
  input  logic             rst_lo,
  slice_alu_mul_if.slave   bus,
  output logic [WIDTH-1:0] y
);
  localparam int CW = $clog2(WIDTH);

  state_e                       state, state_nx;
  logic [DEPTH-1:0][WIDTH-1:0]  ram;
  logic [WIDTH-1:0]             q;
  logic [AW-1:0]                a_l, b_l, ra, rb;
  logic [CW-1:0]                cnt;
  logic                         busy;
  src_e                         src;
  fn_e                          fn_dec, fn;
  dst_e                         dst;
  logic [WIDTH-1:0]             av, bv, r, s, f, y_int, ram_wd, q_wd;
  logic                         c, cout, ovr, ram_we, q_we;

  assign busy   = (state != IDLE);
  assign src    = src_e'(bus.i[I_SRC_LO +: 3]);
  assign fn_dec = fn_e'(bus.i[I_FN_LO +: 3]);
  assign dst    = dst_e'(bus.i[I_DST_LO +: 3]);
  // the sequencer owns the register ports while busy
  assign ra     = busy ? a_l : bus.a;
  assign rb     = busy ? b_l : bus.b;
  assign av     = ram[ra];
  assign bv     = ram[rb];

  always_comb begin
    r  = '0;
    s  = '0;
    fn = fn_dec;
    c  = bus.cin;
    if (busy) begin
      r  = q[0] ? av : '0;
      s  = bv;
      fn = FN_ADD;
      c  = 1'b0;
    end else begin
      case (src)
        SRC_AQ: begin r = av;    s = q;  end
        SRC_AB: begin r = av;    s = bv; end
        SRC_ZQ: s = q;
        SRC_ZB: s = bv;
        SRC_ZA: s = av;
        SRC_DA: begin r = bus.d; s = av; end
        SRC_DQ: begin r = bus.d; s = q;  end
        default: r = bus.d;
      endcase
    end
  end

  slice_alu #(.WIDTH(WIDTH)) u_alu (
    .r(r), .s(s), .cin(c), .fn(fn), .f(f), .cout(cout), .ovr(ovr)
  );

  assign y_int    = (!busy && dst == DST_RAMA) ? av : f;
  assign y        = bus.oe ? y_int : 'z;
  assign bus.cout = cout;
  assign bus.ovr  = ovr;
  assign bus.z    = (f == '0);
  assign bus.fmsb = f[WIDTH-1];
  assign bus.busy = busy;
  assign bus.done = (state == DONE);

  // write-back selection, always addressed at rb
  always_comb begin
    ram_we = 1'b0;
    ram_wd = f;
    q_we   = 1'b0;
    q_wd   = f;
    case (state)
      IDLE: begin
        case (dst)
          DST_QREG:  q_we = 1'b1;
          DST_RAMA,
          DST_RAMF:  ram_we = 1'b1;
          DST_RAMQD: begin
            ram_we = 1'b1; ram_wd = {bus.ser_in, f[WIDTH-1:1]};
            q_we   = 1'b1; q_wd   = {f[0], q[WIDTH-1:1]};
          end
          DST_RAMD:  begin ram_we = 1'b1; ram_wd = {bus.ser_in, f[WIDTH-1:1]}; end
          DST_RAMQU: begin
            ram_we = 1'b1; ram_wd = {f[WIDTH-2:0], q[WIDTH-1]};
            q_we   = 1'b1; q_wd   = {q[WIDTH-2:0], bus.ser_in};
          end
          DST_RAMU:  begin ram_we = 1'b1; ram_wd = {f[WIDTH-2:0], bus.ser_in}; end
          default:   ;
        endcase
      end
      CLR: begin ram_we = 1'b1; ram_wd = '0; end
      // shift the (cout,F) partial sum right; its LSB retires into Q
      MUL: begin
        ram_we = 1'b1; ram_wd = {cout, f[WIDTH-1:1]};
        q_we   = 1'b1; q_wd   = {f[0], q[WIDTH-1:1]};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = CLR;
      CLR:     state_nx = MUL;
      MUL:     if (cnt == CW'(WIDTH-1)) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge cp or negedge rst_lo) begin
    if (!rst_lo) begin
      state <= IDLE;
      ram   <= '0;
      q     <= '0;
      a_l   <= '0;
      b_l   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (ram_we) ram[rb] <= ram_wd;
      if (q_we)   q       <= q_wd;
      if (state == IDLE && bus.start) begin
        a_l <= bus.a;
        b_l <= bus.b;
      end
      if (state == CLR) cnt <= '0;
      else if (state == MUL) cnt <= cnt + 1'b1;
    end
  end
endmodule
